fpu_mul_sequencer: RTL and testbench

Upstream issue and downstream collection stage wrapped around the single-precision multiplier (fpu_mul).
- Accepts tagged operand pairs from a producer over a valid/ready stream and buffers them in a small FIFO.
- Issues one pair at a time to the multiplier's one-cycle valid / one-cycle ready interface.
- Returns each product with its tag on a valid/ready output stream.
- A watchdog converts a hung multiplier operation into a flagged quiet-NaN result.

---
 rtl/fpu_mul_sequencer_if.sv | 40 ++++
 rtl/fpu_mul_sequencer.sv | 132 +++++++++++++
 tb/tb_fpu_mul_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_mul_sequencer_if.sv
// rtl/fpu_mul_sequencer_if.sv - operand, multiplier and result handshakes of fpu_mul_sequencer
// The sequencer uses the slave view; the surrounding producer/multiplier/consumer use the master view.
interface fpu_mul_sequencer_if #(
   parameter int DEPTH = 4,
   parameter int TAG_W = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_a;
   logic [31:0]      in_b;
   logic [TAG_W-1:0] in_tag;

   logic [31:0]      mul_din1;
   logic [31:0]      mul_din2;
   logic             mul_valid;
   logic [31:0]      mul_result;
   logic             mul_ready;

   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_result;
   logic [TAG_W-1:0] out_tag;
   logic             out_timeout;

   logic [CW-1:0]    count;

   modport slave (
      input  in_valid, in_a, in_b, in_tag, mul_result, mul_ready, out_ready,
      output in_ready, mul_din1, mul_din2, mul_valid,
             out_valid, out_result, out_tag, out_timeout, count
   );

   modport master (
      output in_valid, in_a, in_b, in_tag, mul_result, mul_ready, out_ready,
      input  in_ready, mul_din1, mul_din2, mul_valid,
             out_valid, out_result, out_tag, out_timeout, count
   );
endinterface

// File: rtl/fpu_mul_sequencer.sv
// rtl/fpu_mul_sequencer.sv - operand FIFO, issue FSM and watchdog around a single-precision multiplier
// One operation outstanding at a time; a hung multiplier yields a flagged quiet NaN.
module fpu_mul_sequencer #(
   parameter int DEPTH   = 4,
   parameter int TAG_W   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic               clk,
   input  logic               reset,
   fpu_mul_sequencer_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int WW = $clog2(TIMEOUT);
   localparam int EW = 64 + TAG_W;
   localparam logic [31:0]   QNAN   = 32'h7FC0_0000;
   localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RES, HOLD} state_t;

   state_t           state_q;
   logic [EW-1:0]    mem [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic [WW-1:0]    wd_q;
   logic [31:0]      din1_q, din2_q, res_q;
   logic [TAG_W-1:0] tag_q, out_tag_q;
   logic             mul_valid_q, out_valid_q, timeout_q;
   logic             push, pop, nonempty;
   logic [EW-1:0]    head;

   // in_ready looks only at the registered count, so a full FIFO refuses a push even on a pop cycle
   assign nonempty     = (count_q != '0);
   assign bus.in_ready = (count_q < CW'(DEPTH));
   assign push         = bus.in_valid && bus.in_ready;
   assign pop          = nonempty && ((state_q == IDLE) || (state_q == HOLD && bus.out_ready));
   assign head         = mem[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_q] <= {bus.in_a, bus.in_b, bus.in_tag};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         wd_q        <= '0;
         din1_q      <= '0;
         din2_q      <= '0;
         tag_q       <= '0;
         res_q       <= '0;
         out_tag_q   <= '0;
         mul_valid_q <= 1'b0;
         out_valid_q <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         mul_valid_q <= 1'b0;
         if (pop) begin
            din1_q <= head[EW-1 -: 32];
            din2_q <= head[EW-33 -: 32];
            tag_q  <= head[TAG_W-1:0];
         end
         case (state_q)
            IDLE: begin
               if (pop) begin
                  state_q     <= ISSUE;
                  mul_valid_q <= 1'b1;
               end
            end
            ISSUE: begin
               wd_q    <= '0;
               state_q <= WAIT_RES;
            end
            WAIT_RES: begin
               if (wd_q != WD_MAX) wd_q <= wd_q + WW'(1);
               // a real result wins over a watchdog expiry in the same cycle
               if (bus.mul_ready) begin
                  res_q       <= bus.mul_result;
                  out_tag_q   <= tag_q;
                  timeout_q   <= 1'b0;
                  out_valid_q <= 1'b1;
                  state_q     <= HOLD;
               end else if (wd_q == WD_MAX) begin
                  res_q       <= QNAN;
                  out_tag_q   <= tag_q;
                  timeout_q   <= 1'b1;
                  out_valid_q <= 1'b1;
                  state_q     <= HOLD;
               end
            end
            HOLD: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  if (pop) begin
                     state_q     <= ISSUE;
                     mul_valid_q <= 1'b1;
                  end else begin
                     state_q <= IDLE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.mul_din1    = din1_q;
   assign bus.mul_din2    = din2_q;
   assign bus.mul_valid   = mul_valid_q;
   assign bus.out_valid   = out_valid_q;
   assign bus.out_result  = res_q;
   assign bus.out_tag     = out_tag_q;
   assign bus.out_timeout = timeout_q;
   assign bus.count       = count_q;
endmodule

// File: tb/tb_fpu_mul_sequencer.sv
// tb/tb_fpu_mul_sequencer.sv - directed and randomized checks of fpu_mul_sequencer against a scoreboard
// A behavioural multiplier stub answers issues after a programmable latency or hangs on request.
module tb_fpu_mul_sequencer;
   localparam int DEPTH   = 4;
   localparam int TAG_W   = 4;
   localparam int TIMEOUT = 64;
   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   fpu_mul_sequencer_if #(.DEPTH(DEPTH), .TAG_W(TAG_W)) bus ();

   fpu_mul_sequencer #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct packed {
      logic [31:0]      res;
      logic [TAG_W-1:0] tag;
      logic             to;
   } exp_t;

   exp_t model_q[$];
   exp_t pe, ce;
   int   errs = 0, checks = 0, issues = 0, done = 0, outstanding = 0;
   int   stub_lat = 1;
   bit   stub_hang = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] to_dbl(input logic [31:0] f);
      logic [10:0] e;
      e = {3'b000, f[30:23]} + 11'd896;
      return {f[31], e, f[22:0], 29'd0};
   endfunction

   // Reference product for normal operands whose product stays normal
   function automatic logic [31:0] mulf(input logic [31:0] a, input logic [31:0] b);
      real         p;
      logic [63:0] d;
      logic [10:0] e;
      p = $bitstoreal(to_dbl(a)) * $bitstoreal(to_dbl(b));
      d = $realtobits(p);
      e = d[62:52] - 11'd896;
      return {d[63], e[7:0], d[51:29]};
   endfunction

   function automatic logic [31:0] rnd_f();
      logic [31:0] r;
      r = $urandom;
      r[30:23] = 8'(100 + $urandom_range(0, 50));
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] t);
      bit ok;
      ok = 1'b0;
      bus.in_a = a;
      bus.in_b = b;
      bus.in_tag = t;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 300 && !ok; i++) begin
         ok = bus.in_ready;
         step();
      end
      bus.in_valid = 1'b0;
      chk("push_accepted", ok, 1);
   endtask

   task automatic wait_done(input int target);
      for (int i = 0; i < 3000 && done < target; i++) step();
      chk("drain_done", done, target);
   endtask

   task automatic check_reset_vals(input string p);
      chk({p, "_in_ready"}, bus.in_ready, 1);
      chk({p, "_mul_valid"}, bus.mul_valid, 0);
      chk({p, "_out_valid"}, bus.out_valid, 0);
      chk({p, "_out_timeout"}, bus.out_timeout, 0);
      chk({p, "_din1"}, bus.mul_din1, 0);
      chk({p, "_din2"}, bus.mul_din2, 0);
      chk({p, "_out_result"}, bus.out_result, 0);
      chk({p, "_out_tag"}, bus.out_tag, 0);
      chk({p, "_count"}, bus.count, 0);
   endtask

   // Multiplier stub: answers an issue after stub_lat cycles unless hung
   initial begin
      bit          pend;
      int          cnt;
      logic [31:0] sa, sb;
      pend = 1'b0;
      cnt = 0;
      sa = '0;
      sb = '0;
      bus.mul_ready = 1'b0;
      bus.mul_result = '0;
      forever begin
         step();
         bus.mul_ready = 1'b0;
         if (bus.mul_valid && !stub_hang) begin
            pend = 1'b1;
            cnt = stub_lat;
            sa = bus.mul_din1;
            sb = bus.mul_din2;
         end else if (pend) begin
            cnt--;
            if (cnt == 0) begin
               pend = 1'b0;
               bus.mul_ready = 1'b1;
               bus.mul_result = mulf(sa, sb);
            end
         end
      end
   end

   // Scoreboard: every accepted pair must come back once, in order, with the expected product
   always @(negedge clk) begin
      if (reset) begin
         if (bus.mul_valid) begin
            chk("one_outstanding", outstanding, 0);
            outstanding++;
            issues++;
         end
         if (bus.in_valid && bus.in_ready) begin
            pe.res = stub_hang ? QNAN : mulf(bus.in_a, bus.in_b);
            pe.tag = bus.in_tag;
            pe.to  = stub_hang;
            model_q.push_back(pe);
         end
         if (bus.out_valid && bus.out_ready) begin
            chk("result_expected", model_q.size() != 0, 1);
            if (model_q.size() != 0) begin
               ce = model_q.pop_front();
               chk("out_tag", bus.out_tag, ce.tag);
               chk("out_result", bus.out_result, ce.res);
               chk("out_timeout", bus.out_timeout, ce.to);
            end
            outstanding--;
            done++;
         end
         chk("count_le_depth", bus.count <= DEPTH, 1);
      end
   end

   initial begin
      #300000;
      $display("FAIL global_timeout: simulation did not reach the summary");
      $fatal(1, "timeout");
   end

   initial begin
      int          n;
      logic [31:0] a, b;
      bus.in_valid = 1'b0;
      bus.in_a = '0;
      bus.in_b = '0;
      bus.in_tag = '0;
      bus.out_ready = 1'b0;
      repeat (3) step();
      check_reset_vals("rst");
      reset = 1'b1;

      // Single op: 2.0 * 3.0, push-to-issue and ready-to-valid latency
      stub_lat = 3;
      bus.out_ready = 1'b1;
      push(32'h4000_0000, 32'h4040_0000, 4'd3);
      chk("lat_n1_mul_valid", bus.mul_valid, 0);
      step();
      chk("lat_n2_mul_valid", bus.mul_valid, 1);
      step();
      chk("lat_n3_mul_valid", bus.mul_valid, 0);
      n = 0;
      while (!bus.out_valid && n < 50) begin
         step();
         n++;
      end
      chk("res_latency", n, 3);
      chk("single_result", bus.out_result, 32'h40C0_0000);
      chk("single_tag", bus.out_tag, 3);
      chk("single_timeout", bus.out_timeout, 0);
      wait_done(1);
      chk("single_issues", issues, 1);

      // Fill: five pushes with the consumer stalled, sixth held off
      bus.out_ready = 1'b0;
      stub_lat = 2;
      for (int t = 0; t < 5; t++) push(rnd_f(), rnd_f(), TAG_W'(t));
      repeat (3) step();
      chk("fill_count", bus.count, 4);
      chk("fill_in_ready", bus.in_ready, 0);
      chk("fill_hold_valid", bus.out_valid, 1);
      bus.in_valid = 1'b1;
      repeat (4) begin
         step();
         chk("sixth_held", bus.in_ready, 0);
      end
      bus.out_ready = 1'b1;
      push(rnd_f(), rnd_f(), 4'd5);
      wait_done(7);

      // Backpressure: result held steady for 20 cycles, no re-issue
      bus.out_ready = 1'b0;
      stub_lat = 4;
      a = rnd_f();
      b = rnd_f();
      push(a, b, 4'd7);
      push(rnd_f(), rnd_f(), 4'd8);
      for (int i = 0; i < 50 && !bus.out_valid; i++) step();
      chk("bp_reached_hold", bus.out_valid, 1);
      repeat (20) begin
         step();
         chk("bp_out_valid", bus.out_valid, 1);
         chk("bp_out_result", bus.out_result, mulf(a, b));
         chk("bp_out_tag", bus.out_tag, 7);
         chk("bp_mul_valid", bus.mul_valid, 0);
      end
      chk("bp_issues", issues, 8);
      bus.out_ready = 1'b1;
      wait_done(9);

      // Watchdog: hung multiplier, then a normal op
      stub_hang = 1'b1;
      push(rnd_f(), rnd_f(), 4'd9);
      step();
      chk("wd_issue", bus.mul_valid, 1);
      step();
      n = 0;
      while (!bus.out_valid && n < 200) begin
         step();
         n++;
      end
      chk("wd_latency", n, TIMEOUT);
      chk("wd_result", bus.out_result, QNAN);
      chk("wd_timeout", bus.out_timeout, 1);
      wait_done(10);
      stub_hang = 1'b0;
      push(32'h3F80_0000, 32'h4080_0000, 4'd10);
      for (int i = 0; i < 50 && !bus.out_valid; i++) step();
      chk("post_wd_result", bus.out_result, 32'h4080_0000);
      chk("post_wd_timeout", bus.out_timeout, 0);
      wait_done(11);

      // Reset mid-op with two entries queued; the stub answers late
      bus.out_ready = 1'b0;
      stub_lat = 10;
      push(rnd_f(), rnd_f(), 4'd11);
      push(rnd_f(), rnd_f(), 4'd12);
      push(rnd_f(), rnd_f(), 4'd13);
      repeat (2) step();
      chk("pre_rst_count", bus.count, 2);
      chk("pre_rst_out_valid", bus.out_valid, 0);
      reset = 1'b0;
      #1;
      check_reset_vals("rst_mid");
      model_q.delete();
      outstanding = 0;
      repeat (2) step();
      reset = 1'b1;
      repeat (15) begin
         step();
         chk("post_rst_out_valid", bus.out_valid, 0);
         chk("post_rst_mul_valid", bus.mul_valid, 0);
      end
      chk("post_rst_count", bus.count, 0);

      // Wrap: 3*DEPTH ops with random consumer stalls and multiplier latency
      fork
         begin
            for (int i = 0; i < 3 * DEPTH; i++) begin
               repeat ($urandom_range(0, 2)) step();
               stub_lat = $urandom_range(1, 4);
               push(rnd_f(), rnd_f(), TAG_W'(i));
            end
         end
         begin
            for (int c = 0; c < 3000 && done < 11 + 3 * DEPTH; c++) begin
               bus.out_ready = 1'($urandom_range(0, 1));
               step();
            end
            bus.out_ready = 1'b1;
         end
      join
      wait_done(11 + 3 * DEPTH);
      chk("wrap_queue_empty", model_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
